snd_regctl_mc: RTL and testbench
================================

// Module: snd_regctl_mc
// PURPOSE
//  Multi-channel register controller for the sound IP, on the 16-bit register bus.
//  Holds per-channel playback registers: buffer address, size, volume, loop and command.
//  Delivers each command to its channel engine through a valid/ready handshake.
//  Collects per-channel completion events into a maskable interrupt.
// PARAMETERS
//  NCH     4      number of channels, 1..16
//  ADDR_W  29     width of SNDADDR/SNDSIZE per channel
//  BASE    4'd3   WRADDR/RDADDR[15:12] value that selects this block
// PORTS
//  ACLK       in   1          clock
//  ARST       in   1          reset, synchronous, active-high
//  WRADDR     in   16         write byte address
//  BYTEEN     in   4          write byte enables
//  WREN       in   1          write strobe, one cycle per access
//  WDATA      in   32         write data
//  RDADDR     in   16         read byte address
//  RDEN       in   1          read strobe
//  RDATA      out  32         read data, registered
//  SNDADDR    out  NCH*ADDR_W per-channel buffer address, ch0 in LSBs
//  SNDSIZE    out  NCH*ADDR_W per-channel buffer size
//  VOLUME     out  NCH*8      per-channel volume
//  LOOP       out  NCH        per-channel loop enable
//  CMD        out  NCH*2      pending command per channel, valid while CMD_VALID[ch]
//  CMD_VALID  out  NCH        command pending per channel
//  CMD_READY  in   NCH        channel engine accepts command
//  BUSY       in   NCH        channel engine playing, status only
//  DONE       in   NCH        one-cycle pulse: channel finished playback
//  IRQ        out  1          level interrupt = |(IRQ_PEND & IRQ_EN)
// BEHAVIOUR
//  Decode: access is hit = EN && ADDR[15:12]==BASE.
//   ADDR[11:8]!=4'hF: ch=ADDR[7:4], reg=ADDR[3:2]. ch>=NCH writes are ignored and read 0.
//   Per-channel regs:
//    0 SNDADDR[ADDR_W-1:0] RW, per byte lane; WDATA bits above ADDR_W are dropped.
//    1 SNDSIZE             RW, per byte lane.
//    2 VOLUME[7:0]         RW, lane 0; takes WDATA[7:0].
//    3 CTRL {LOOP[2],CMD[1:0]} RW, lane 0; see command handshake below.
//   ADDR[11:8]==4'hF, global regs:
//    0 STATUS   RO {CMD_VALID[NCH-1:0]<<16 | BUSY[NCH-1:0]}
//    1 IRQ_PEND W1C, bits [NCH-1:0]
//    2 IRQ_EN   RW, bits [NCH-1:0]
//   Unmapped reads return 0. Unmapped writes have no effect.
//  Read: RDATA updates the cycle after a RDEN hit (1-cycle latency).
//   RDATA holds its value when there is no hit.
//   Reads of global regs reflect state as of the RDEN cycle.
//  Command handshake, per channel, 2 states: IDLE (CMD_VALID=0) and PEND (CMD_VALID=1).
//   CTRL write with BYTEEN[0]: LOOP and CMD latch; state goes to PEND.
//   PEND & CMD_READY: state goes to IDLE on the next cycle.
//   CTRL write in PEND: CMD is overwritten (latest wins) and CMD_VALID stays 1.
//   CTRL write and CMD_READY in the same cycle: new command latches and CMD_VALID stays 1.
//   CMD and LOOP are stable while CMD_VALID=1, apart from such overwrites.
//  Interrupt: DONE[ch] sets IRQ_PEND[ch].
//   A W1C of 1 clears IRQ_PEND bits; DONE and W1C on the same bit in the same cycle: bit stays set.
//   IRQ is registered, so it asserts 1 cycle after IRQ_PEND&IRQ_EN becomes nonzero.
//  Reset values: all registers, RDATA, CMD_VALID, IRQ_PEND, IRQ_EN and IRQ are 0.
//   ARST in PEND drops CMD_VALID without waiting for READY.
//  A write and a read in the same cycle to the same reg: read returns the old value.
// STRUCTURE
//  Package snd_pkg: register offsets (REG_ADDR/SIZE/VOL/CTRL, GREG_STATUS/PEND/EN),
//   GLOBAL_PAGE=4'hF, CMD encodings (2'd0 stop, 2'd1 play, 2'd2 pause, 2'd3 rsvd).
//  Sub-module snd_regctl_ch: one channel's regs and the IDLE/PEND FSM, generated NCH times.
//  Top level: decode, read mux, IRQ logic.
// TESTING
//  1 Reset, then read every reg -> RDATA=0, CMD_VALID=0, IRQ=0.
//  2 Write ch2 SNDADDR 0xFFFF_FFFF, BYTEEN=4'b0101 -> reads 0x00FF_00FF;
//    SNDADDR[2*29+:29] matches; ch0, ch1, ch3 are unchanged.
//  3 Write ch1 CTRL 0x5 with READY low -> CMD_VALID[1]=1, CMD=1, LOOP=1.
//    Write 0x2 -> CMD=2, CMD_VALID stays 1. Pulse READY -> CMD_VALID=0 next cycle.
//  4 Write CTRL in the same cycle as CMD_READY=1 -> CMD_VALID stays 1 with the new CMD.
//  5 IRQ_EN=0x1; pulse DONE[0] -> IRQ=1 after 1 cycle.
//    W1C 0x1 together with another DONE[0] -> IRQ_PEND[0] stays 1. A lone W1C clears it and IRQ=0.
//  6 NCH=4: write ch5 VOLUME -> no output change, read 0.
//    Global STATUS with BUSY=4'b1010 -> 0x0000_000A.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared definitions for the sound register controller: register offsets,
// page decode, command encodings, channel FSM states and a byte-lane helper.
package snd_pkg;

    // Per-channel register indices (ADDR[3:2])
    localparam logic [1:0] REG_ADDR = 2'd0;
    localparam logic [1:0] REG_SIZE = 2'd1;
    localparam logic [1:0] REG_VOL  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // Global register indices (ADDR[3:2]) inside the global page
    localparam logic [1:0] GREG_STATUS = 2'd0;
    localparam logic [1:0] GREG_PEND   = 2'd1;
    localparam logic [1:0] GREG_EN     = 2'd2;

    // ADDR[11:8] value selecting the global register page
    localparam logic [3:0] GLOBAL_PAGE = 4'hF;

    // Command encodings carried on CMD
    localparam logic [1:0] CMD_STOP  = 2'd0;
    localparam logic [1:0] CMD_PLAY  = 2'd1;
    localparam logic [1:0] CMD_PAUSE = 2'd2;
    localparam logic [1:0] CMD_RSVD  = 2'd3;

    // Per-channel command handshake states
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } ch_state_e;

    // Expand 4 byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/snd_regctl_ch.sv
// One sound channel: buffer address/size, volume, loop flag and the
// IDLE/PEND command handshake towards the channel engine.
// ADDR_W is expected to be at most 32 (registers live in one bus word).
module snd_regctl_ch
    import snd_pkg::*;
#(
    parameter int ADDR_W = 29
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              wr_sel,
    input  logic [1:0]        wr_reg,
    input  logic [3:0]        byteen,
    input  logic [31:0]       wdata,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] snd_addr,
    output logic [ADDR_W-1:0] snd_size,
    output logic [7:0]        volume,
    output logic              loop,
    output logic [1:0]        cmd,
    output logic              cmd_valid
);

    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] size_reg;
    logic [7:0]        vol_reg;
    logic              loop_reg;
    logic [1:0]        cmd_reg;
    ch_state_e         state_reg;
    ch_state_e         state_next;

    logic [31:0] lane_mask;
    logic        ctrl_wr;

    assign lane_mask = byte_mask(byteen);
    assign ctrl_wr   = wr_sel && (wr_reg == REG_CTRL) && byteen[0];

    // Register file: byte-lane merge for address/size, lane 0 for volume/ctrl
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            addr_reg <= '0;
            size_reg <= '0;
            vol_reg  <= '0;
            loop_reg <= 1'b0;
            cmd_reg  <= CMD_STOP;
        end else begin
            if (wr_sel && (wr_reg == REG_ADDR)) begin
                addr_reg <= ADDR_W'((32'(addr_reg) & ~lane_mask) | (wdata & lane_mask));
            end
            if (wr_sel && (wr_reg == REG_SIZE)) begin
                size_reg <= ADDR_W'((32'(size_reg) & ~lane_mask) | (wdata & lane_mask));
            end
            if (wr_sel && (wr_reg == REG_VOL) && byteen[0]) begin
                vol_reg <= wdata[7:0];
            end
            // A new command always wins, even over a concurrent accept
            if (ctrl_wr) begin
                loop_reg <= wdata[2];
                cmd_reg  <= wdata[1:0];
            end
        end
    end

    // Handshake state register; reset drops a pending command immediately
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_reg <= CH_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake next-state: write arms PEND, READY returns to IDLE unless re-armed
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CH_IDLE: begin
                if (ctrl_wr) begin
                    state_next = CH_PEND;
                end
            end
            CH_PEND: begin
                if (ctrl_wr) begin
                    state_next = CH_PEND;
                end else if (cmd_ready) begin
                    state_next = CH_IDLE;
                end
            end
            default: state_next = CH_IDLE;
        endcase
    end

    assign snd_addr  = addr_reg;
    assign snd_size  = size_reg;
    assign volume    = vol_reg;
    assign loop      = loop_reg;
    assign cmd       = cmd_reg;
    assign cmd_valid = (state_reg == CH_PEND);

endmodule

// File: rtl/snd_regctl_mc.sv
// Multi-channel sound register controller: bus decode, NCH channel
// register blocks, registered read mux and the maskable completion IRQ.
module snd_regctl_mc
    import snd_pkg::*;
#(
    parameter int         NCH    = 4,
    parameter int         ADDR_W = 29,
    parameter logic [3:0] BASE   = 4'd3
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    input  logic [15:0]           WRADDR,
    input  logic [3:0]            BYTEEN,
    input  logic                  WREN,
    input  logic [31:0]           WDATA,
    input  logic [15:0]           RDADDR,
    input  logic                  RDEN,
    output logic [31:0]           RDATA,
    output logic [NCH*ADDR_W-1:0] SNDADDR,
    output logic [NCH*ADDR_W-1:0] SNDSIZE,
    output logic [NCH*8-1:0]      VOLUME,
    output logic [NCH-1:0]        LOOP,
    output logic [NCH*2-1:0]      CMD,
    output logic [NCH-1:0]        CMD_VALID,
    input  logic [NCH-1:0]        CMD_READY,
    input  logic [NCH-1:0]        BUSY,
    input  logic [NCH-1:0]        DONE,
    output logic                  IRQ
);

    // Bus decode
    logic wr_hit;
    logic wr_global;
    logic rd_hit;
    logic rd_global;

    assign wr_hit    = WREN && (WRADDR[15:12] == BASE);
    assign wr_global = (WRADDR[11:8] == GLOBAL_PAGE);
    assign rd_hit    = RDEN && (RDADDR[15:12] == BASE);
    assign rd_global = (RDADDR[11:8] == GLOBAL_PAGE);

    // Per-channel views
    logic [NCH-1:0]    ch_wr_sel;
    logic [NCH-1:0]    ch_rd_sel;
    logic [31:0]       ch_rd_data [NCH];
    logic [ADDR_W-1:0] ch_addr    [NCH];
    logic [ADDR_W-1:0] ch_size    [NCH];
    logic [7:0]        ch_vol     [NCH];
    logic [NCH-1:0]    ch_loop;
    logic [1:0]        ch_cmd     [NCH];
    logic [NCH-1:0]    ch_valid;

    // Global interrupt state
    logic [NCH-1:0] irq_pend_reg;
    logic [NCH-1:0] irq_pend_next;
    logic [NCH-1:0] irq_en_reg;
    logic [NCH-1:0] irq_en_next;
    logic [NCH-1:0] glb_lane;
    logic [NCH-1:0] pend_clr;
    logic           irq_reg;

    logic [31:0] rdata_reg;
    logic [31:0] rd_mux;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            // Channels not present in the address space simply never match
            assign ch_wr_sel[gi] = wr_hit && !wr_global && (WRADDR[7:4] == 4'(gi));
            assign ch_rd_sel[gi] = (RDADDR[7:4] == 4'(gi));
            // Global bit gi lives in byte lane gi/8
            assign glb_lane[gi]  = BYTEEN[gi/8];

            snd_regctl_ch #(
                .ADDR_W (ADDR_W)
            ) u_ch (
                .ACLK      (ACLK),
                .ARST      (ARST),
                .wr_sel    (ch_wr_sel[gi]),
                .wr_reg    (WRADDR[3:2]),
                .byteen    (BYTEEN),
                .wdata     (WDATA),
                .cmd_ready (CMD_READY[gi]),
                .snd_addr  (ch_addr[gi]),
                .snd_size  (ch_size[gi]),
                .volume    (ch_vol[gi]),
                .loop      (ch_loop[gi]),
                .cmd       (ch_cmd[gi]),
                .cmd_valid (ch_valid[gi])
            );

            assign SNDADDR[gi*ADDR_W +: ADDR_W] = ch_addr[gi];
            assign SNDSIZE[gi*ADDR_W +: ADDR_W] = ch_size[gi];
            assign VOLUME[gi*8 +: 8]            = ch_vol[gi];
            assign CMD[gi*2 +: 2]               = ch_cmd[gi];

            // Channel register word for the read mux
            always_comb begin
                ch_rd_data[gi] = '0;
                case (RDADDR[3:2])
                    REG_ADDR: ch_rd_data[gi] = 32'(ch_addr[gi]);
                    REG_SIZE: ch_rd_data[gi] = 32'(ch_size[gi]);
                    REG_VOL:  ch_rd_data[gi] = {24'd0, ch_vol[gi]};
                    REG_CTRL: ch_rd_data[gi] = {29'd0, ch_loop[gi], ch_cmd[gi]};
                    default:  ch_rd_data[gi] = '0;
                endcase
            end
        end
    endgenerate

    assign LOOP      = ch_loop;
    assign CMD_VALID = ch_valid;

    // Interrupt pending/enable next state: DONE beats a same-cycle W1C
    always_comb begin
        pend_clr    = '0;
        irq_en_next = irq_en_reg;
        if (wr_hit && wr_global && (WRADDR[3:2] == GREG_PEND)) begin
            pend_clr = WDATA[NCH-1:0] & glb_lane;
        end
        if (wr_hit && wr_global && (WRADDR[3:2] == GREG_EN)) begin
            irq_en_next = (irq_en_reg & ~glb_lane) | (WDATA[NCH-1:0] & glb_lane);
        end
        irq_pend_next = (irq_pend_reg & ~pend_clr) | DONE;
    end

    // Interrupt registers; IRQ is a registered OR of enabled pending bits
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            irq_pend_reg <= '0;
            irq_en_reg   <= '0;
            irq_reg      <= 1'b0;
        end else begin
            irq_pend_reg <= irq_pend_next;
            irq_en_reg   <= irq_en_next;
            irq_reg      <= |(irq_pend_reg & irq_en_reg);
        end
    end

    // Read mux on current state, so a same-cycle write is not yet visible
    always_comb begin
        rd_mux = '0;
        if (rd_global) begin
            case (RDADDR[3:2])
                GREG_STATUS: rd_mux = (32'(ch_valid) << 16) | 32'(BUSY);
                GREG_PEND:   rd_mux = 32'(irq_pend_reg);
                GREG_EN:     rd_mux = 32'(irq_en_reg);
                default:     rd_mux = '0;
            endcase
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_rd_sel[c]) begin
                    rd_mux = ch_rd_data[c];
                end
            end
        end
    end

    // Registered read data, held when there is no read hit
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            rdata_reg <= '0;
        end else if (rd_hit) begin
            rdata_reg <= rd_mux;
        end
    end

    assign RDATA = rdata_reg;
    assign IRQ   = irq_reg;

    // Word-aligned bus: the byte offset bits carry no information
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, WRADDR[1:0], RDADDR[1:0]};

endmodule

// File: tb/tb_snd_regctl_mc.sv
// Directed self-checking bench for snd_regctl_mc (NCH=4, ADDR_W=29, BASE=3).
module tb_snd_regctl_mc;

    localparam int NCH    = 4;
    localparam int ADDR_W = 29;

    logic                  ACLK = 1'b0;
    logic                  ARST;
    logic [15:0]           WRADDR;
    logic [3:0]            BYTEEN;
    logic                  WREN;
    logic [31:0]           WDATA;
    logic [15:0]           RDADDR;
    logic                  RDEN;
    logic [31:0]           RDATA;
    logic [NCH*ADDR_W-1:0] SNDADDR;
    logic [NCH*ADDR_W-1:0] SNDSIZE;
    logic [NCH*8-1:0]      VOLUME;
    logic [NCH-1:0]        LOOP;
    logic [NCH*2-1:0]      CMD;
    logic [NCH-1:0]        CMD_VALID;
    logic [NCH-1:0]        CMD_READY;
    logic [NCH-1:0]        BUSY;
    logic [NCH-1:0]        DONE;
    logic                  IRQ;

    int checks = 0;
    int errors = 0;

    snd_regctl_mc #(
        .NCH    (NCH),
        .ADDR_W (ADDR_W),
        .BASE   (4'd3)
    ) dut (
        .ACLK      (ACLK),
        .ARST      (ARST),
        .WRADDR    (WRADDR),
        .BYTEEN    (BYTEEN),
        .WREN      (WREN),
        .WDATA     (WDATA),
        .RDADDR    (RDADDR),
        .RDEN      (RDEN),
        .RDATA     (RDATA),
        .SNDADDR   (SNDADDR),
        .SNDSIZE   (SNDSIZE),
        .VOLUME    (VOLUME),
        .LOOP      (LOOP),
        .CMD       (CMD),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .IRQ       (IRQ)
    );

    always #5 ACLK = ~ACLK;

    // Compare, count, and report one line per check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    function automatic logic [15:0] ch_addr(input int ch, input int r);
        return 16'h3000 | 16'(ch << 4) | 16'(r << 2);
    endfunction

    function automatic logic [15:0] g_addr(input int r);
        return 16'h3F00 | 16'(r << 2);
    endfunction

    // One-cycle write; inputs change on the falling edge
    task automatic bus_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
        WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
        @(negedge ACLK);
        WREN = 1'b0; BYTEEN = 4'h0;
    endtask

    // One-cycle read; RDATA is valid after the following rising edge
    task automatic bus_read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        RDADDR = a; RDEN = 1'b1;
        @(negedge ACLK);
        RDEN = 1'b0;
        check(tag, RDATA, exp);
    endtask

    initial begin
        ARST = 1'b1; WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
        RDADDR = '0; RDEN = 1'b0; CMD_READY = '0; BUSY = '0; DONE = '0;
        repeat (3) @(negedge ACLK);
        ARST = 1'b0;
        @(negedge ACLK);

        // 1: reset state
        check("rst_rdata", RDATA, 32'h0);
        check("rst_cmd_valid", 32'(CMD_VALID), 32'h0);
        check("rst_irq", 32'(IRQ), 32'h0);
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 4; r++) begin
                bus_read_check($sformatf("rst_ch%0d_r%0d", c, r), ch_addr(c, r), 32'h0);
            end
        end
        for (int r = 0; r < 3; r++) begin
            bus_read_check($sformatf("rst_g%0d", r), g_addr(r), 32'h0);
        end

        // 2: byte-lane write to ch2 SNDADDR, bits above 29 dropped
        bus_write(ch_addr(2, 0), 4'b0101, 32'hFFFF_FFFF);
        bus_read_check("ch2_addr_rd", ch_addr(2, 0), 32'h00FF_00FF);
        check("ch2_addr_out", 32'(SNDADDR[2*ADDR_W +: ADDR_W]), 32'h00FF_00FF);
        check("ch0_addr_out", 32'(SNDADDR[0*ADDR_W +: ADDR_W]), 32'h0);
        check("ch1_addr_out", 32'(SNDADDR[1*ADDR_W +: ADDR_W]), 32'h0);
        check("ch3_addr_out", 32'(SNDADDR[3*ADDR_W +: ADDR_W]), 32'h0);
        bus_write(ch_addr(3, 1), 4'b1111, 32'hFFFF_FFFF);
        check("ch3_size_out", 32'(SNDSIZE[3*ADDR_W +: ADDR_W]), 32'h1FFF_FFFF);
        // Write outside BASE is ignored
        bus_write(16'h2008, 4'b1111, 32'h0000_00AA);
        check("base_miss_vol", VOLUME, 32'h0);

        // 3: command handshake on ch1
        bus_write(ch_addr(1, 3), 4'b0001, 32'h5);
        check("ch1_valid_set", 32'(CMD_VALID), 32'h2);
        check("ch1_cmd_play", 32'(CMD[2 +: 2]), 32'h1);
        check("ch1_loop", 32'(LOOP), 32'h2);
        bus_read_check("status_pend", g_addr(0), 32'h0002_0000);
        bus_write(ch_addr(1, 3), 4'b0001, 32'h2);
        check("ch1_cmd_over", 32'(CMD[2 +: 2]), 32'h2);
        check("ch1_valid_hold", 32'(CMD_VALID), 32'h2);
        check("ch1_loop_clr", 32'(LOOP), 32'h0);
        CMD_READY = 4'b0010;
        @(negedge ACLK);
        CMD_READY = '0;
        check("ch1_valid_drop", 32'(CMD_VALID), 32'h0);

        // 4: CTRL write in the same cycle as READY while pending
        bus_write(ch_addr(1, 3), 4'b0001, 32'h3);
        check("ch1_pend_again", 32'(CMD_VALID), 32'h2);
        CMD_READY = 4'b0010;
        bus_write(ch_addr(1, 3), 4'b0001, 32'h1);
        CMD_READY = '0;
        check("ch1_wr_ready_valid", 32'(CMD_VALID), 32'h2);
        check("ch1_wr_ready_cmd", 32'(CMD[2 +: 2]), 32'h1);
        CMD_READY = 4'b0010;
        @(negedge ACLK);
        CMD_READY = '0;
        check("ch1_final_idle", 32'(CMD_VALID), 32'h0);

        // 5: interrupt
        bus_write(g_addr(2), 4'b0001, 32'h1);
        DONE = 4'b0001;
        @(negedge ACLK);
        DONE = '0;
        check("irq_latency", 32'(IRQ), 32'h0);
        @(negedge ACLK);
        check("irq_set", 32'(IRQ), 32'h1);
        DONE = 4'b0001;
        bus_write(g_addr(1), 4'b0001, 32'h1);
        DONE = '0;
        bus_read_check("pend_done_wins", g_addr(1), 32'h1);
        check("irq_still", 32'(IRQ), 32'h1);
        bus_write(g_addr(1), 4'b0001, 32'h1);
        bus_read_check("pend_cleared", g_addr(1), 32'h0);
        check("irq_clear", 32'(IRQ), 32'h0);

        // 6: absent channel, status, unmapped, hold, same-cycle write/read
        bus_read_check("ch2_addr_again", ch_addr(2, 0), 32'h00FF_00FF);
        bus_write(ch_addr(5, 2), 4'b0001, 32'h55);
        check("ch5_no_vol", VOLUME, 32'h0);
        bus_read_check("ch5_read", ch_addr(5, 2), 32'h0);
        BUSY = 4'b1010;
        bus_read_check("status_busy", g_addr(0), 32'h0000_000A);
        BUSY = '0;
        bus_read_check("enable_rd", g_addr(2), 32'h1);
        RDADDR = ch_addr(2, 0);
        @(negedge ACLK);
        check("rdata_hold", RDATA, 32'h1);
        bus_read_check("global_unmapped", g_addr(3), 32'h0);
        WRADDR = ch_addr(0, 2); BYTEEN = 4'b0001; WDATA = 32'h12; WREN = 1'b1;
        RDADDR = ch_addr(0, 2); RDEN = 1'b1;
        @(negedge ACLK);
        WREN = 1'b0; RDEN = 1'b0; BYTEEN = 4'h0;
        check("wr_rd_old", RDATA, 32'h0);
        bus_read_check("wr_rd_new", ch_addr(0, 2), 32'h12);
        check("ch0_vol_out", VOLUME, 32'h12);

        // Reset while pending drops CMD_VALID
        bus_write(ch_addr(3, 3), 4'b0001, 32'h1);
        check("ch3_pend", 32'(CMD_VALID), 32'h8);
        ARST = 1'b1;
        @(negedge ACLK);
        ARST = 1'b0;
        check("rst_drops_valid", 32'(CMD_VALID), 32'h0);
        check("rst_clears_vol", VOLUME, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
